// File: rtl/frat_pkg.sv
// frat_pkg: shared rename constants and physical-ID / free-list pointer types
package frat_pkg;
  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 34;
  localparam int ID_W = 6;
  localparam int DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [ID_W-1:0] phys_id_t;
  typedef logic [PTR_W-1:0] fl_ptr_t;
endpackage

// File: rtl/freelist_ctrl_if.sv
// freelist_ctrl_if: rename allocation / retire reclaim / flush bundle of the free list
interface freelist_ctrl_if;
  import frat_pkg::*;
  logic alloc_req;
  logic alloc_gnt;
  phys_id_t alloc_id;
  logic stall_out;
  logic retire_valid;
  logic retire_has_dest;
  phys_id_t retire_free_id;
  logic flush;
  phys_id_t free_count;
  logic err;
  modport master (
    output alloc_req, retire_valid, retire_has_dest, retire_free_id, flush,
    input alloc_gnt, alloc_id, stall_out, free_count, err
  );
  modport slave (
    input alloc_req, retire_valid, retire_has_dest, retire_free_id, flush,
    output alloc_gnt, alloc_id, stall_out, free_count, err
  );
endinterface

// File: rtl/freelist_ptr_inc.sv
// freelist_ptr_inc: modulo-DEPTH pointer incrementer with enable
module freelist_ptr_inc
  import frat_pkg::*;
(
  input  fl_ptr_t ptr_i,
  input  logic    en_i,
  output fl_ptr_t ptr_o
);
  always_comb ptr_o = !en_i ? ptr_i : (ptr_i == fl_ptr_t'(DEPTH - 1)) ? '0 : ptr_i + fl_ptr_t'(1);
endmodule

// File: rtl/freelist_ctrl.sv
// freelist_ctrl: physical-register free list with spec/commit heads and tail, flush rewind.
// Define FREELIST_BYPASS_EN to let a retiring ID be granted in the same cycle when empty.
module freelist_ctrl
  import frat_pkg::*;
(
  input logic clk_i,
  input logic rst_ni,
  freelist_ctrl_if.slave fl
);
  phys_id_t buf_q [DEPTH];
  fl_ptr_t spec_q, commit_q, tail_q;
  fl_ptr_t spec_inc, spec_d, commit_d, tail_d;
  phys_id_t count_q, count_d;
  logic err_q, retire, retire_ok, empty, bypass, gnt;
  assign retire = fl.retire_valid & fl.retire_has_dest;
  assign empty = count_q == '0;
`ifdef FREELIST_BYPASS_EN
  assign bypass = empty & retire;
`else
  assign bypass = 1'b0;
`endif
  // a full list means no speculative allocation is outstanding, so nothing may retire
  assign retire_ok = retire & (count_q != phys_id_t'(DEPTH));
  assign gnt = fl.alloc_req & (!empty | bypass) & !fl.flush;
  assign spec_d = fl.flush ? commit_d : spec_inc;
  assign count_d = fl.flush ? phys_id_t'(DEPTH) : count_q + phys_id_t'(retire_ok) - phys_id_t'(gnt);
  assign fl.alloc_gnt = gnt;
  assign fl.alloc_id = bypass ? fl.retire_free_id : buf_q[spec_q];
  assign fl.stall_out = empty & !bypass;
  assign fl.free_count = count_q;
  assign fl.err = err_q;
  freelist_ptr_inc u_spec (.ptr_i(spec_q), .en_i(gnt), .ptr_o(spec_inc));
  freelist_ptr_inc u_commit (.ptr_i(commit_q), .en_i(retire_ok), .ptr_o(commit_d));
  freelist_ptr_inc u_tail (.ptr_i(tail_q), .en_i(retire_ok), .ptr_o(tail_d));
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= phys_id_t'(NUM_ARCH + i);
      spec_q <= '0;
      commit_q <= '0;
      tail_q <= '0;
      count_q <= phys_id_t'(DEPTH);
      err_q <= 1'b0;
    end else begin
      if (retire_ok) buf_q[tail_q] <= fl.retire_free_id;
      spec_q <= spec_d;
      commit_q <= commit_d;
      tail_q <= tail_d;
      count_q <= count_d;
      err_q <= err_q | (retire & !retire_ok);
    end
endmodule

// File: tb/tb_freelist_ctrl.sv
// tb_freelist_ctrl: directed checks of allocation, reclaim, flush rewind, wrap and error paths
module tb_freelist_ctrl;
  import frat_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  logic [5:0] q[$];
  logic [5:0] a0, a1, rid, exp_id;
  freelist_ctrl_if fl();
  freelist_ctrl dut (.clk_i(clk), .rst_ni(rst_n), .fl(fl));
  always #5 clk = ~clk;
  task automatic chk(string tag, int obs, int exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic req, logic rv, logic rd, logic [5:0] id, logic f);
    fl.alloc_req = req;
    fl.retire_valid = rv;
    fl.retire_has_dest = rd;
    fl.retire_free_id = id;
    fl.flush = f;
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0);
    tick;
    tick;
    chk("rst_gnt", int'(fl.alloc_gnt), 0);
    chk("rst_stall", int'(fl.stall_out), 0);
    chk("rst_id", int'(fl.alloc_id), 34);
    chk("rst_count", int'(fl.free_count), 30);
    chk("rst_err", int'(fl.err), 0);
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 30; i++) begin
      drive(1, 0, 0, 0, 0);
      chk("drain_gnt", int'(fl.alloc_gnt), 1);
      chk("drain_id", int'(fl.alloc_id), 34 + i);
      tick;
    end
    drive(1, 0, 0, 0, 0);
    chk("empty_stall", int'(fl.stall_out), 1);
    chk("empty_gnt", int'(fl.alloc_gnt), 0);
    chk("empty_count", int'(fl.free_count), 0);
    drive(1, 1, 1, 5, 0);
`ifdef FREELIST_BYPASS_EN
    chk("byp_gnt", int'(fl.alloc_gnt), 1);
    chk("byp_id", int'(fl.alloc_id), 5);
    chk("byp_stall", int'(fl.stall_out), 0);
    tick;
    drive(0, 0, 0, 0, 0);
    chk("byp_count", int'(fl.free_count), 0);
    chk("byp_stall2", int'(fl.stall_out), 1);
`else
    chk("refill_gnt", int'(fl.alloc_gnt), 0);
    chk("refill_stall", int'(fl.stall_out), 1);
    tick;
    drive(0, 0, 0, 0, 0);
    chk("refill_id", int'(fl.alloc_id), 5);
    chk("refill_count", int'(fl.free_count), 1);
    chk("refill_stall2", int'(fl.stall_out), 0);
`endif
    rst_n = 1'b0;
    #1;
    chk("async_count", int'(fl.free_count), 30);
    chk("async_id", int'(fl.alloc_id), 34);
    chk("async_stall", int'(fl.stall_out), 0);
    tick;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0);
      chk("pre_flush_id", int'(fl.alloc_id), 34 + i);
      tick;
    end
    drive(0, 1, 1, 7, 0);
    tick;
    drive(0, 0, 0, 0, 0);
    chk("pre_flush_count", int'(fl.free_count), 27);
    drive(1, 0, 0, 0, 1);
    chk("flush_gnt", int'(fl.alloc_gnt), 0);
    tick;
    drive(0, 0, 0, 0, 0);
    chk("flush_count", int'(fl.free_count), 30);
    chk("flush_id", int'(fl.alloc_id), 35);
    drive(1, 0, 0, 0, 0);
    chk("steady_first", int'(fl.alloc_id), 35);
    tick;
    for (int v = 36; v < 64; v++) q.push_back(6'(v));
    q.push_back(6'd7);
    for (int i = 0; i < 100; i++) begin
      rid = 6'(i * 7 + 3);
      drive(1, 1, 1, rid, 0);
      exp_id = q.pop_front();
      chk("steady_id", int'(fl.alloc_id), int'(exp_id));
      chk("steady_gnt", int'(fl.alloc_gnt), 1);
      q.push_back(rid);
      tick;
    end
    drive(0, 0, 0, 0, 0);
    chk("steady_count", int'(fl.free_count), 29);
    chk("steady_err", int'(fl.err), 0);
    drive(1, 0, 0, 0, 0);
    a0 = q.pop_front();
    chk("spec_a0", int'(fl.alloc_id), int'(a0));
    tick;
    drive(1, 0, 0, 0, 0);
    a1 = q.pop_front();
    chk("spec_a1", int'(fl.alloc_id), int'(a1));
    tick;
    drive(1, 1, 1, 9, 1);
    chk("flush_ret_gnt", int'(fl.alloc_gnt), 0);
    tick;
    drive(0, 0, 0, 0, 0);
    chk("flush_ret_count", int'(fl.free_count), 30);
    chk("flush_ret_id", int'(fl.alloc_id), int'(a0));
    q.push_front(a1);
    q.push_front(a0);
    q.push_back(6'd9);
    for (int i = 0; i < 30; i++) begin
      drive(1, 0, 0, 0, 0);
      exp_id = q.pop_front();
      chk("rewind_id", int'(fl.alloc_id), int'(exp_id));
      tick;
    end
    drive(0, 0, 0, 0, 0);
    chk("rewind_stall", int'(fl.stall_out), 1);
    chk("rewind_err", int'(fl.err), 0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    drive(0, 1, 1, 12, 0);
    tick;
    drive(0, 0, 0, 0, 0);
    chk("ovf_err", int'(fl.err), 1);
    chk("ovf_count", int'(fl.free_count), 30);
    chk("ovf_id", int'(fl.alloc_id), 34);
    tick;
    tick;
    chk("ovf_sticky", int'(fl.err), 1);
    rst_n = 1'b0;
    #1;
    chk("ovf_rst_err", int'(fl.err), 0);
    tick;
    rst_n = 1'b1;
    tick;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
